// File: rtl/hc_pkg.sv
// hc_pkg: shared definitions for the host-channel read path.
//   HC_RD_TAG_W / HC_RD_CID_W  : client-local tag and client-id widths
//   HC_CL_ADDR_W / HC_MDATA_W  : CCI-P cache-line address and mdata widths
//   t_hc_rd_mdata              : layout of c0 mdata {pad, cid, tag}
package hc_pkg;

    localparam int HC_RD_TAG_W  = 8;
    localparam int HC_RD_CID_W  = 4;
    localparam int HC_CL_ADDR_W = 42;
    localparam int HC_MDATA_W   = 16;
    localparam int HC_PAD_W     = HC_MDATA_W - HC_RD_CID_W - HC_RD_TAG_W;

    typedef struct packed {
        logic [HC_PAD_W-1:0]    pad;
        logic [HC_RD_CID_W-1:0] cid;
        logic [HC_RD_TAG_W-1:0] tag;
    } t_hc_rd_mdata;

endpackage

// File: rtl/hc_rr_arbiter.sv
// hc_rr_arbiter: round-robin arbiter, one-hot grant.
//   clk, reset_n : clock, asynchronous active-low reset
//   req          : request vector
//   grant_en     : advance the pointer past the current winner
//   grant        : one-hot grant (combinational from req and pointer)
module hc_rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] req,
    input  logic         grant_en,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] winIdx;
    logic          found;
    int            scanIdx;

    // Scan from ptr upward, wrapping; first requester wins.
    always_comb begin
        grant   = '0;
        winIdx  = '0;
        found   = 1'b0;
        scanIdx = 0;
        for (int i = 0; i < N; i++) begin
            scanIdx = int'(ptr) + i;
            if (scanIdx >= N) scanIdx = scanIdx - N;
            if (!found && req[scanIdx]) begin
                found         = 1'b1;
                grant[scanIdx] = 1'b1;
                winIdx        = PW'(scanIdx);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (grant_en && found) begin
            ptr <= (winIdx == PW'(N - 1)) ? '0 : winIdx + PW'(1);
        end
    end

endmodule

// File: rtl/hc_rd_arbiter.sv
// hc_rd_arbiter: shares the CCI-P c0 read-request channel among N_CLIENTS
// requesters, tags mdata with the client id and routes responses back.
//   clk, reset_n                      : pClk, asynchronous active-low reset
//   clt_rd_valid/addr/tag/ready       : per-client request handshake
//   c0tx_almfull                      : blocks new grants
//   c0tx_valid/addr/mdata             : registered c0 Tx read request
//   c0rx_valid/mdata/data             : c0 read response in
//   clt_rsp_valid/tag/data            : one-hot strobe + shared response bus
//   idle                              : nothing outstanding, no pending Tx
//   err                               : sticky, response with no owner
module hc_rd_arbiter
    import hc_pkg::*;
#(
    parameter int N_CLIENTS       = 4,
    parameter int MAX_OUTSTANDING = 64
) (
    input  logic                                     clk,
    input  logic                                     reset_n,
    input  logic [N_CLIENTS-1:0]                     clt_rd_valid,
    input  logic [N_CLIENTS-1:0][HC_CL_ADDR_W-1:0]   clt_rd_addr,
    input  logic [N_CLIENTS-1:0][HC_RD_TAG_W-1:0]    clt_rd_tag,
    output logic [N_CLIENTS-1:0]                     clt_rd_ready,
    input  logic                                     c0tx_almfull,
    output logic                                     c0tx_valid,
    output logic [HC_CL_ADDR_W-1:0]                  c0tx_addr,
    output logic [HC_MDATA_W-1:0]                    c0tx_mdata,
    input  logic                                     c0rx_valid,
    input  logic [HC_MDATA_W-1:0]                    c0rx_mdata,
    input  logic [511:0]                             c0rx_data,
    output logic [N_CLIENTS-1:0]                     clt_rsp_valid,
    output logic [HC_RD_TAG_W-1:0]                   clt_rsp_tag,
    output logic [511:0]                             clt_rsp_data,
    output logic                                     idle,
    output logic                                     err
);

    localparam int              CNT_W   = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    logic [N_CLIENTS-1:0][CNT_W-1:0] outstanding;
    logic [N_CLIENTS-1:0]            eligible;
    logic [N_CLIENTS-1:0]            grant;
    logic [N_CLIENTS-1:0]            rspHit;
    logic [HC_RD_CID_W-1:0]          grantCid;
    logic [HC_CL_ADDR_W-1:0]         grantAddr;
    logic [HC_RD_TAG_W-1:0]          grantTag;
    logic                            xfer;
    t_hc_rd_mdata                    rspMd;
    t_hc_rd_mdata                    txMd;
    logic                            unusedPad;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < N_CLIENTS; i++)
            eligible[i] = clt_rd_valid[i] && (outstanding[i] != CNT_MAX) && !c0tx_almfull;
    end

    // Every grant is a transfer (grant implies valid), so always advance.
    hc_rr_arbiter #(.N(N_CLIENTS)) uArb (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (eligible),
        .grant_en (1'b1),
        .grant    (grant)
    );

    // Grant is combinational; gate it so ready stays low throughout reset.
    assign clt_rd_ready = grant & {N_CLIENTS{reset_n}};
    assign xfer         = |clt_rd_ready;

    always_comb begin
        grantCid  = '0;
        grantAddr = '0;
        grantTag  = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            if (grant[i]) begin
                grantCid  = HC_RD_CID_W'(i);
                grantAddr = clt_rd_addr[i];
                grantTag  = clt_rd_tag[i];
            end
        end
    end

    always_comb begin
        txMd     = '0;
        txMd.cid = grantCid;
        txMd.tag = grantTag;
    end

    assign rspMd     = c0rx_mdata;
    assign unusedPad = ^rspMd.pad;

    // A response is accepted only for an in-range id holding a credit;
    // ids >= N_CLIENTS match no row and fall through to err.
    always_comb begin
        rspHit = '0;
        for (int i = 0; i < N_CLIENTS; i++)
            rspHit[i] = c0rx_valid && (rspMd.cid == HC_RD_CID_W'(i)) && (outstanding[i] != '0);
    end

    // Issue and response for the same client cancel out.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outstanding <= '0;
        end else begin
            for (int i = 0; i < N_CLIENTS; i++) begin
                case ({grant[i], rspHit[i]})
                    2'b10:   outstanding[i] <= outstanding[i] + CNT_W'(1);
                    2'b01:   outstanding[i] <= outstanding[i] - CNT_W'(1);
                    default: outstanding[i] <= outstanding[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            c0tx_valid    <= 1'b0;
            c0tx_addr     <= '0;
            c0tx_mdata    <= '0;
            clt_rsp_valid <= '0;
            clt_rsp_tag   <= '0;
            clt_rsp_data  <= '0;
            err           <= 1'b0;
        end else begin
            c0tx_valid <= xfer;
            if (xfer) begin
                c0tx_addr  <= grantAddr;
                c0tx_mdata <= txMd;
            end
            clt_rsp_valid <= rspHit;
            if (|rspHit) begin
                clt_rsp_tag  <= rspMd.tag;
                clt_rsp_data <= c0rx_data;
            end
            if (c0rx_valid && !(|rspHit))
                err <= 1'b1;
        end
    end

    assign idle = (outstanding == '0) && !c0tx_valid;

endmodule

// File: tb/tb_hc_rd_arbiter.sv
module tb_hc_rd_arbiter;

    localparam int N    = 4;
    localparam int MAXO = 4;

    logic                clk = 1'b0;
    logic                reset_n = 1'b1;
    logic [N-1:0]        clt_rd_valid;
    logic [N-1:0][41:0]  clt_rd_addr;
    logic [N-1:0][7:0]   clt_rd_tag;
    logic [N-1:0]        clt_rd_ready;
    logic                c0tx_almfull;
    logic                c0tx_valid;
    logic [41:0]         c0tx_addr;
    logic [15:0]         c0tx_mdata;
    logic                c0rx_valid;
    logic [15:0]         c0rx_mdata;
    logic [511:0]        c0rx_data;
    logic [N-1:0]        clt_rsp_valid;
    logic [7:0]          clt_rsp_tag;
    logic [511:0]        clt_rsp_data;
    logic                idle;
    logic                err;

    int nChk  = 0;
    int nPass = 0;

    // Reference model: credit counts, tags in flight, priority pointer.
    int          mOut[N];
    int          mPtr;
    logic        mErr;
    logic [7:0]  pend[N][$];
    logic        expTxV;
    logic [41:0] expTxA;
    logic [15:0] expTxM;
    logic [N-1:0] expRspV;
    logic [7:0]  expRspT;
    logic [511:0] expRspD;

    hc_rd_arbiter #(.N_CLIENTS(N), .MAX_OUTSTANDING(MAXO)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .clt_rd_valid  (clt_rd_valid),
        .clt_rd_addr   (clt_rd_addr),
        .clt_rd_tag    (clt_rd_tag),
        .clt_rd_ready  (clt_rd_ready),
        .c0tx_almfull  (c0tx_almfull),
        .c0tx_valid    (c0tx_valid),
        .c0tx_addr     (c0tx_addr),
        .c0tx_mdata    (c0tx_mdata),
        .c0rx_valid    (c0rx_valid),
        .c0rx_mdata    (c0rx_mdata),
        .c0rx_data     (c0rx_data),
        .clt_rsp_valid (clt_rsp_valid),
        .clt_rsp_tag   (clt_rsp_tag),
        .clt_rsp_data  (clt_rsp_data),
        .idle          (idle),
        .err           (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clrIn();
        clt_rd_valid = '0;
        clt_rd_addr  = '0;
        clt_rd_tag   = '0;
        c0tx_almfull = 1'b0;
        c0rx_valid   = 1'b0;
        c0rx_mdata   = '0;
        c0rx_data    = '0;
    endtask

    task automatic doReset();
        clrIn();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int c = 0; c < N; c++) begin
            mOut[c] = 0;
            pend[c].delete();
        end
        mPtr = 0; mErr = 1'b0;
        expTxV = 1'b0; expTxA = '0; expTxM = '0;
        expRspV = '0; expRspT = '0; expRspD = '0;
    endtask

    // First requesting client with a free credit, scanning from mPtr.
    function automatic int modelGrant();
        int c;
        if (c0tx_almfull) return -1;
        for (int k = 0; k < N; k++) begin
            c = (mPtr + k) % N;
            if (clt_rd_valid[c] && mOut[c] < MAXO) return c;
        end
        return -1;
    endfunction

    task automatic modelEdge(input int g);
        int   cid;
        logic hit;
        cid = int'(c0rx_mdata[11:8]);
        hit = 1'b0;
        if (c0rx_valid && cid < N) hit = (mOut[cid] > 0);
        expRspV = '0;
        if (hit) begin
            expRspV[cid] = 1'b1;
            expRspT = c0rx_mdata[7:0];
            expRspD = c0rx_data;
        end
        if (c0rx_valid && !hit) mErr = 1'b1;
        expTxV = (g >= 0);
        if (g >= 0) begin
            expTxA = clt_rd_addr[g];
            expTxM = {4'h0, 4'(g), clt_rd_tag[g]};
            mOut[g]++;
            mPtr = (g + 1) % N;
        end
        if (hit) mOut[cid]--;
    endtask

    task automatic test_reset();
        clrIn();
        reset_n = 1'b1;
        #2;
        reset_n = 1'b0;
        clt_rd_valid = '1;
        c0rx_valid = 1'b1;
        c0rx_mdata = 16'h0700;
        #1;
        nChk++; if (clt_rd_ready !== 4'b0000) $display("FAIL reset_ready: got %b want 0000", clt_rd_ready); else nPass++;
        nChk++; if (c0tx_valid !== 1'b0) $display("FAIL reset_txvalid: got %b want 0", c0tx_valid); else nPass++;
        nChk++; if (idle !== 1'b1) $display("FAIL reset_idle: got %b want 1", idle); else nPass++;
        tick(); tick();
        nChk++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else nPass++;
        nChk++; if (clt_rsp_valid !== 4'b0000) $display("FAIL reset_rspvalid: got %b want 0000", clt_rsp_valid); else nPass++;
        nChk++; if (c0tx_mdata !== 16'h0000 || c0tx_addr !== 42'h0) $display("FAIL reset_txbus: got %h/%h want 0/0", c0tx_addr, c0tx_mdata); else nPass++;
        nChk++; if (clt_rsp_tag !== 8'h00 || clt_rsp_data !== 512'h0) $display("FAIL reset_rspbus: got tag %h want 00", clt_rsp_tag); else nPass++;
        doReset();
    endtask

    task automatic test_single();
        logic [511:0] d;
        doReset();
        clt_rd_valid = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            clt_rd_addr[0] = 42'h100 + 42'(i);
            clt_rd_tag[0]  = 8'(i);
            #1;
            nChk++; if (clt_rd_ready !== 4'b0001) $display("FAIL single_ready%0d: got %b want 0001", i, clt_rd_ready); else nPass++;
            tick();
            nChk++; if (c0tx_valid !== 1'b1 || c0tx_mdata !== 16'(i) || c0tx_addr !== 42'h100 + 42'(i))
                $display("FAIL single_tx%0d: got v%b %h/%h want v1 %h/%h", i, c0tx_valid, c0tx_addr, c0tx_mdata, 42'h100 + 42'(i), 16'(i));
            else nPass++;
        end
        clt_rd_valid = '0;
        tick();
        nChk++; if (c0tx_valid !== 1'b0 || idle !== 1'b0) $display("FAIL single_busy: got v%b idle%b want v0 idle0", c0tx_valid, idle); else nPass++;
        for (int i = 0; i < 4; i++) begin
            d = {16{$urandom()}};
            c0rx_valid = 1'b1;
            c0rx_mdata = 16'(i);
            c0rx_data  = d;
            tick();
            nChk++; if (clt_rsp_valid !== 4'b0001 || clt_rsp_tag !== 8'(i) || clt_rsp_data !== d)
                $display("FAIL single_rsp%0d: got %b tag %h want 0001 tag %h", i, clt_rsp_valid, clt_rsp_tag, 8'(i));
            else nPass++;
        end
        c0rx_valid = 1'b0;
        tick();
        nChk++; if (clt_rsp_valid !== 4'b0000 || idle !== 1'b1 || err !== 1'b0)
            $display("FAIL single_end: got rsp %b idle %b err %b want 0000 1 0", clt_rsp_valid, idle, err);
        else nPass++;
    endtask

    task automatic test_fairness();
        int cnt[N];
        doReset();
        for (int c = 0; c < N; c++) cnt[c] = 0;
        clt_rd_valid = '1;
        for (int k = 0; k < 16; k++) begin
            #1;
            nChk++; if (clt_rd_ready !== 4'(1 << (k % N))) $display("FAIL fair_order%0d: got %b want %b", k, clt_rd_ready, 4'(1 << (k % N))); else nPass++;
            for (int c = 0; c < N; c++) if (clt_rd_ready[c]) cnt[c]++;
            tick();
        end
        for (int c = 0; c < N; c++) begin
            nChk++; if (cnt[c] != 4) $display("FAIL fair_count%0d: got %0d want 4", c, cnt[c]); else nPass++;
        end
        #1;
        nChk++; if (clt_rd_ready !== 4'b0000) $display("FAIL fair_full: got %b want 0000", clt_rd_ready); else nPass++;
    endtask

    task automatic test_credit();
        doReset();
        clt_rd_valid = 4'b0100;
        for (int k = 0; k < 4; k++) begin
            clt_rd_tag[2] = 8'(5 + k);
            #1;
            nChk++; if (clt_rd_ready !== 4'b0100) $display("FAIL credit_ready%0d: got %b want 0100", k, clt_rd_ready); else nPass++;
            tick();
            nChk++; if (c0tx_mdata !== {8'h02, 8'(5 + k)}) $display("FAIL credit_mdata%0d: got %h want %h", k, c0tx_mdata, {8'h02, 8'(5 + k)}); else nPass++;
        end
        clt_rd_tag[2] = 8'h09;
        for (int k = 0; k < 3; k++) begin
            #1;
            nChk++; if (clt_rd_ready !== 4'b0000) $display("FAIL credit_block%0d: got %b want 0000", k, clt_rd_ready); else nPass++;
            tick();
        end
        c0rx_valid = 1'b1;
        c0rx_mdata = 16'h0205;
        #1;
        nChk++; if (clt_rd_ready !== 4'b0000) $display("FAIL credit_samecyc: got %b want 0000", clt_rd_ready); else nPass++;
        tick();
        c0rx_valid = 1'b0;
        #1;
        nChk++; if (clt_rd_ready !== 4'b0100) $display("FAIL credit_reenable: got %b want 0100", clt_rd_ready); else nPass++;
        nChk++; if (clt_rsp_valid !== 4'b0100 || clt_rsp_tag !== 8'h05) $display("FAIL credit_rsp: got %b tag %h want 0100 tag 05", clt_rsp_valid, clt_rsp_tag); else nPass++;
        tick();
        clt_rd_valid = '0;
        nChk++; if (c0tx_valid !== 1'b1 || c0tx_mdata !== 16'h0209) $display("FAIL credit_tx: got v%b %h want v1 0209", c0tx_valid, c0tx_mdata); else nPass++;
    endtask

    task automatic test_almfull();
        doReset();
        clt_rd_valid = '1;
        #1;
        nChk++; if (clt_rd_ready !== 4'b0001) $display("FAIL af_pre: got %b want 0001", clt_rd_ready); else nPass++;
        tick();
        c0tx_almfull = 1'b1;
        #1;
        nChk++; if (c0tx_valid !== 1'b1) $display("FAIL af_inflight: got %b want 1", c0tx_valid); else nPass++;
        nChk++; if (clt_rd_ready !== 4'b0000) $display("FAIL af_block0: got %b want 0000", clt_rd_ready); else nPass++;
        for (int k = 1; k < 10; k++) begin
            tick();
            nChk++; if (clt_rd_ready !== 4'b0000 || c0tx_valid !== 1'b0)
                $display("FAIL af_block%0d: got rdy %b txv %b want 0000 0", k, clt_rd_ready, c0tx_valid);
            else nPass++;
        end
        tick();
        c0tx_almfull = 1'b0;
        #1;
        nChk++; if (clt_rd_ready !== 4'b0010) $display("FAIL af_resume: got %b want 0010", clt_rd_ready); else nPass++;
        tick();
        clt_rd_valid = '0;
        nChk++; if (c0tx_valid !== 1'b1 || c0tx_mdata !== 16'h0100) $display("FAIL af_tx: got v%b %h want v1 0100", c0tx_valid, c0tx_mdata); else nPass++;
    endtask

    task automatic test_bad();
        doReset();
        c0rx_valid = 1'b1;
        c0rx_mdata = 16'h0700;
        tick();
        c0rx_valid = 1'b0;
        nChk++; if (clt_rsp_valid !== 4'b0000 || err !== 1'b1) $display("FAIL bad_id: got rsp %b err %b want 0000 1", clt_rsp_valid, err); else nPass++;
        doReset();
        clt_rd_valid = 4'b0001;
        tick();
        clt_rd_valid = '0;
        c0rx_valid = 1'b1;
        c0rx_mdata = 16'h0100;
        tick();
        c0rx_valid = 1'b0;
        nChk++; if (clt_rsp_valid !== 4'b0000 || err !== 1'b1) $display("FAIL bad_nocredit: got rsp %b err %b want 0000 1", clt_rsp_valid, err); else nPass++;
        nChk++; if (idle !== 1'b0) $display("FAIL bad_idle: got %b want 0", idle); else nPass++;
        repeat (3) tick();
        nChk++; if (err !== 1'b1) $display("FAIL bad_sticky: got %b want 1", err); else nPass++;
    endtask

    task automatic test_same_cycle();
        doReset();
        clt_rd_valid = 4'b1000;
        clt_rd_tag[3] = 8'h01;
        #1;
        nChk++; if (clt_rd_ready !== 4'b1000) $display("FAIL same_first: got %b want 1000", clt_rd_ready); else nPass++;
        tick();
        clt_rd_tag[3] = 8'h02;
        c0rx_valid = 1'b1;
        c0rx_mdata = 16'h0301;
        #1;
        nChk++; if (clt_rd_ready !== 4'b1000) $display("FAIL same_ready: got %b want 1000", clt_rd_ready); else nPass++;
        tick();
        nChk++; if (clt_rsp_valid !== 4'b1000 || clt_rsp_tag !== 8'h01 || c0tx_mdata !== 16'h0302)
            $display("FAIL same_both: got rsp %b tag %h mdata %h want 1000 01 0302", clt_rsp_valid, clt_rsp_tag, c0tx_mdata);
        else nPass++;
        clt_rd_valid = '0;
        c0rx_mdata = 16'h0302;
        tick();
        c0rx_valid = 1'b0;
        nChk++; if (clt_rsp_valid !== 4'b1000 || err !== 1'b0) $display("FAIL same_drain: got rsp %b err %b want 1000 0", clt_rsp_valid, err); else nPass++;
        tick();
        nChk++; if (idle !== 1'b1) $display("FAIL same_idle: got %b want 1", idle); else nPass++;
        // Reset in the middle of traffic, away from a clock edge.
        clt_rd_valid = '1;
        tick(); tick();
        #2;
        reset_n = 1'b0;
        #1;
        nChk++; if (c0tx_valid !== 1'b0 || clt_rd_ready !== 4'b0000 || idle !== 1'b1 || c0tx_mdata !== 16'h0)
            $display("FAIL midreset: got txv %b rdy %b idle %b mdata %h want 0 0000 1 0000", c0tx_valid, clt_rd_ready, idle, c0tx_mdata);
        else nPass++;
        clt_rd_valid = '0;
        tick();
        reset_n = 1'b1;
        c0rx_valid = 1'b1;
        c0rx_mdata = 16'h0300;
        tick();
        c0rx_valid = 1'b0;
        nChk++; if (clt_rsp_valid !== 4'b0000 || err !== 1'b1) $display("FAIL late_rsp: got rsp %b err %b want 0000 1", clt_rsp_valid, err); else nPass++;
    endtask

    task automatic test_random();
        logic [N-1:0] granted;
        logic         expIdle;
        int           g, s, c;
        doReset();
        granted = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            expIdle = !expTxV;
            for (int k = 0; k < N; k++) if (mOut[k] != 0) expIdle = 1'b0;
            nChk++; if (c0tx_valid !== expTxV) $display("FAIL rnd_txv@%0d: got %b want %b", cyc, c0tx_valid, expTxV); else nPass++;
            if (expTxV) begin
                nChk++; if (c0tx_addr !== expTxA || c0tx_mdata !== expTxM)
                    $display("FAIL rnd_tx@%0d: got %h/%h want %h/%h", cyc, c0tx_addr, c0tx_mdata, expTxA, expTxM);
                else nPass++;
            end
            nChk++; if (clt_rsp_valid !== expRspV) $display("FAIL rnd_rspv@%0d: got %b want %b", cyc, clt_rsp_valid, expRspV); else nPass++;
            if (expRspV != '0) begin
                nChk++; if (clt_rsp_tag !== expRspT || clt_rsp_data !== expRspD)
                    $display("FAIL rnd_rsp@%0d: got tag %h want %h", cyc, clt_rsp_tag, expRspT);
                else nPass++;
            end
            nChk++; if (idle !== expIdle || err !== mErr) $display("FAIL rnd_stat@%0d: got idle %b err %b want %b %b", cyc, idle, err, expIdle, mErr); else nPass++;

            // Requests stay put until granted; fresh ones afterwards.
            for (int k = 0; k < N; k++) begin
                if (!clt_rd_valid[k] || granted[k]) begin
                    clt_rd_valid[k] = ($urandom() % 3) != 0;
                    clt_rd_addr[k]  = 42'({$urandom(), $urandom()});
                    clt_rd_tag[k]   = 8'($urandom());
                end
            end
            c0tx_almfull = ($urandom() % 5) == 0;
            c0rx_valid = 1'b0;
            c0rx_mdata = '0;
            for (int w = 0; w < 16; w++) c0rx_data[w*32 +: 32] = $urandom();
            if (($urandom() % 60) == 0) begin
                c0rx_valid = 1'b1;
                c0rx_mdata = {4'h0, 4'(4 + $urandom() % 12), 8'($urandom())};
            end else if (($urandom() % 2) == 0) begin
                s = int'($urandom() % N);
                for (int k = 0; k < N; k++) begin
                    c = (s + k) % N;
                    if (!c0rx_valid && pend[c].size() > 0) begin
                        c0rx_valid = 1'b1;
                        c0rx_mdata = {4'h0, 4'(c), pend[c].pop_front()};
                    end
                end
            end
            #1;
            g = modelGrant();
            granted = '0;
            if (g >= 0) granted[g] = 1'b1;
            nChk++; if (clt_rd_ready !== granted) $display("FAIL rnd_ready@%0d: got %b want %b", cyc, clt_rd_ready, granted); else nPass++;
            if (g >= 0) pend[g].push_back(clt_rd_tag[g]);
            modelEdge(g);
            tick();
        end
        clrIn();
    endtask

    initial begin
        clrIn();
        test_reset();
        test_single();
        test_fairness();
        test_credit();
        test_almfull();
        test_bad();
        test_same_cycle();
        test_random();
        $display("%0d/%0d checks passed", nPass, nChk);
        $finish;
    end

endmodule
